// File: rtl/sram_responder.sv
// ============================================================================
// Module   : sram_responder
// Purpose  : Single-port SRAM slave with byte-lane writes, 1-cycle registered
//            reads, and an MMIO window holding LED, TIMER and SCRATCH registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] MMIO_BASE = 16'h1FAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer
);

  localparam int          c_DEPTH       = 1 << ADDR_W;
  localparam logic [15:0] c_OFF_LED     = 16'hF000;
  localparam logic [15:0] c_OFF_TIMER   = 16'hE000;
  localparam logic [15:0] c_OFF_SCRATCH = 16'hD000;

  logic [31:0]       r_mem [0:c_DEPTH-1];
  logic [31:0]       r_rdata;
  logic [15:0]       r_led;
  logic [31:0]       r_timer;
  logic [31:0]       r_scratch;

  logic              w_mmio;
  logic [15:0]       w_off;
  logic              w_sel_led;
  logic              w_sel_timer;
  logic              w_sel_scratch;
  logic              w_write;
  logic              w_read;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdata;
  logic              w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  wen);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) v[8*i +: 8] = new_v[8*i +: 8];
    end
    return v;
  endfunction

  assign w_mmio        = (sram_addr[31:16] == MMIO_BASE);
  assign w_off         = {sram_addr[15:2], 2'b00};
  assign w_sel_led     = w_mmio && (w_off == c_OFF_LED);
  assign w_sel_timer   = w_mmio && (w_off == c_OFF_TIMER);
  assign w_sel_scratch = w_mmio && (w_off == c_OFF_SCRATCH);
  assign w_write       = sram_en && (sram_wen != 4'b0000);
  assign w_read        = sram_en && (sram_wen == 4'b0000);
  assign w_idx         = sram_addr[ADDR_W+1:2];
  assign w_unused      = ^sram_addr[1:0];

  // RAM array has no reset; writes are blocked while resetn is low so an
  // access in flight at reset assertion is discarded.
  always_ff @(posedge clk) begin
    if (resetn && w_write && !w_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (!w_mmio)            w_rdata = r_mem[w_idx];
    else if (w_sel_led)     w_rdata = {16'h0, r_led};
    else if (w_sel_timer)   w_rdata = r_timer;
    else if (w_sel_scratch) w_rdata = r_scratch;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata   <= 32'h0;
      r_led     <= 16'h0;
      r_timer   <= 32'h0;
      r_scratch <= 32'h0;
    end else begin
      if (w_read) r_rdata <= w_rdata;
      if (w_write && w_sel_led) begin
        if (sram_wen[0]) r_led[7:0]  <= sram_wdata[7:0];
        if (sram_wen[1]) r_led[15:8] <= sram_wdata[15:8];
      end
      if (w_write && w_sel_scratch) r_scratch <= f_merge(r_scratch, sram_wdata, sram_wen);
      // A TIMER write replaces this cycle's increment.
      if (w_write && w_sel_timer) r_timer <= f_merge(r_timer, sram_wdata, sram_wen);
      else                        r_timer <= r_timer + 32'd1;
    end
  end

  assign sram_rdata = r_rdata;
  assign led        = r_led;
  assign timer      = r_timer;

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// Module   : tb_sram_responder
// Purpose  : Self-checking bench for sram_responder: directed scenarios plus
//            randomized traffic against a behavioural memory/register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_responder;

  localparam int          ADDR_W    = 10;
  localparam logic [15:0] MMIO_BASE = 16'h1FAF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [31:0] timer;

  int n_tests = 0;
  int n_fail  = 0;

  sram_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .timer      (timer)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] wen);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) if (wen[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  task automatic test_reset();
    #2;
    n_tests++; if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", sram_rdata, 32'h0); end
    n_tests++; if (led !== 16'h0)        begin n_fail++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
    @(posedge clk); #1;
    n_tests++; if (timer !== 32'h0)      begin n_fail++; $display("FAIL reset_timer_held: got %h want %h", timer, 32'h0); end
    #3 resetn = 1'b1;
    step();
    n_tests++; if (timer !== 32'd1)      begin n_fail++; $display("FAIL timer_first_inc: got %h want %h", timer, 32'd1); end
    step();
    n_tests++; if (timer !== 32'd2)      begin n_fail++; $display("FAIL timer_second_inc: got %h want %h", timer, 32'd2); end
  endtask

  task automatic test_ram_rw();
    drive(1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678); step();
    drive(1'b1, 4'h0, 32'h0000_0040, 32'h0);          step();
    n_tests++; if (sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_back_to_back: got %h want %h", sram_rdata, 32'h1234_5678); end
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 4'hF, 32'h0000_0044, 32'hAABB_CCDD);  step();
    drive(1'b1, 4'h5, 32'h0000_0044, 32'h1122_3344);  step();
    n_tests++; if (sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdata_hold_on_write: got %h want %h", sram_rdata, 32'h1234_5678); end
    drive(1'b1, 4'h0, 32'h0000_0044, 32'h0);           step();
    n_tests++; if (sram_rdata !== 32'hAA22_CC44) begin n_fail++; $display("FAIL byte_lanes: got %h want %h", sram_rdata, 32'hAA22_CC44); end
  endtask

  task automatic test_led();
    drive(1'b1, 4'hF, 32'h1FAF_F000, 32'h0001_FFFF); step();
    n_tests++; if (led !== 16'hFFFF) begin n_fail++; $display("FAIL led_write: got %h want %h", led, 16'hFFFF); end
    drive(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);          step();
    n_tests++; if (sram_rdata !== 32'h0000_FFFF) begin n_fail++; $display("FAIL led_readback: got %h want %h", sram_rdata, 32'h0000_FFFF); end
  endtask

  task automatic test_timer_wrap();
    drive(1'b1, 4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE); step();
    n_tests++; if (timer !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_load: got %h want %h", timer, 32'hFFFF_FFFE); end
    drive(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);          step();
    n_tests++; if (timer !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_inc_max: got %h want %h", timer, 32'hFFFF_FFFF); end
    n_tests++; if (sram_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_read_pre_inc: got %h want %h", sram_rdata, 32'hFFFF_FFFE); end
    drive(1'b0, 4'h0, 32'h0, 32'h0);                   step();
    n_tests++; if (timer !== 32'h0) begin n_fail++; $display("FAIL timer_wrap: got %h want %h", timer, 32'h0); end
  endtask

  task automatic test_unmapped();
    drive(1'b1, 4'h0, 32'h1FAF_0004, 32'h0); step();
    n_tests++; if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", sram_rdata, 32'h0); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'hF, 32'h1FAF_F000, 32'h0000_1234); step();
      n_tests++; if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_hold[%0d]: got %h want %h", k, sram_rdata, 32'h0); end
      n_tests++; if (led !== 16'hFFFF)     begin n_fail++; $display("FAIL idle_no_write[%0d]: led %h want %h", k, led, 16'hFFFF); end
    end
  endtask

  task automatic test_reset_midcycle();
    drive(1'b1, 4'hF, 32'h1FAF_D000, 32'hDEAD_BEEF); step();
    drive(1'b1, 4'hF, 32'h0000_0080, 32'hCAFE_F00D); step();
    drive(1'b1, 4'h0, 32'h0000_0080, 32'h0);          step();
    n_tests++; if (sram_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL pre_reset_read: got %h want %h", sram_rdata, 32'hCAFE_F00D); end
    drive(1'b1, 4'hF, 32'h1FAF_F000, 32'h0000_5555);
    #3 resetn = 1'b0;
    #1;
    n_tests++; if (led !== 16'h0)        begin n_fail++; $display("FAIL async_reset_led: got %h want %h", led, 16'h0); end
    n_tests++; if (timer !== 32'h0)      begin n_fail++; $display("FAIL async_reset_timer: got %h want %h", timer, 32'h0); end
    n_tests++; if (sram_rdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_rdata: got %h want %h", sram_rdata, 32'h0); end
    drive(1'b1, 4'hF, 32'h0000_0080, 32'h0BAD_BAD0);
    step();
    n_tests++; if (led !== 16'h0 || timer !== 32'h0) begin n_fail++; $display("FAIL reset_held: led %h timer %h want 0 0", led, timer); end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #3 resetn = 1'b1;
    step();
    n_tests++; if (timer !== 32'd1) begin n_fail++; $display("FAIL post_reset_timer: got %h want %h", timer, 32'd1); end
    drive(1'b1, 4'h0, 32'h0000_0080, 32'h0); step();
    n_tests++; if (sram_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_survives_reset: got %h want %h", sram_rdata, 32'hCAFE_F00D); end
    drive(1'b1, 4'h0, 32'h0000_0044, 32'h0); step();
    n_tests++; if (sram_rdata !== 32'hAA22_CC44) begin n_fail++; $display("FAIL ram_survives_reset2: got %h want %h", sram_rdata, 32'hAA22_CC44); end
  endtask

  task automatic test_random();
    logic [31:0] m_ram [0:15];
    logic [15:0] m_led;
    logic [31:0] m_timer, m_scratch, m_rdata, rv, addr, wdata;
    logic [3:0]  wen;
    logic        en;
    int          kind, idx;
    logic [15:0] offs [0:3];
    offs[0] = 16'h0004; offs[1] = 16'hF004; offs[2] = 16'h1000; offs[3] = 16'hC000;
    m_led = 16'h0; m_scratch = 32'h0;
    drive(1'b1, 4'h0, 32'h1FAF_D000, 32'h0); step();
    m_rdata = 32'h0;
    n_tests++; if (sram_rdata !== m_rdata) begin n_fail++; $display("FAIL scratch_reset: got %h want %h", sram_rdata, m_rdata); end
    m_timer = $urandom;
    drive(1'b1, 4'hF, 32'h1FAF_E000, m_timer); step();
    n_tests++; if (timer !== m_timer) begin n_fail++; $display("FAIL rand_timer_seed: got %h want %h", timer, m_timer); end
    for (int i = 0; i < 16; i++) begin
      m_ram[i] = $urandom;
      drive(1'b1, 4'hF, {20'h0, 10'(i), 2'b00}, m_ram[i]); step();
      m_timer = m_timer + 32'd1;
    end
    for (int k = 0; k < 300; k++) begin
      en    = ($urandom_range(0, 9) != 0);
      wen   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wdata = $urandom;
      idx   = 0;
      if ($urandom_range(0, 9) < 6) begin
        kind = 0;
        idx  = $urandom_range(0, 15);
        addr = {16'($urandom_range(0, 16'h1F00)), 4'($urandom), 10'(idx), 2'($urandom)};
      end else begin
        kind = $urandom_range(1, 4);
        case (kind)
          1:       addr = {MMIO_BASE, 16'hF000};
          2:       addr = {MMIO_BASE, 16'hE000};
          3:       addr = {MMIO_BASE, 16'hD000};
          default: addr = {MMIO_BASE, offs[$urandom_range(0, 3)]};
        endcase
        addr[1:0] = 2'($urandom);
      end
      case (kind)
        0:       rv = m_ram[idx];
        1:       rv = {16'h0, m_led};
        2:       rv = m_timer;
        3:       rv = m_scratch;
        default: rv = 32'h0;
      endcase
      if (en && wen == 4'h0) m_rdata = rv;
      if (en && wen != 4'h0 && kind == 2) m_timer = merge(m_timer, wdata, wen);
      else                                 m_timer = m_timer + 32'd1;
      if (en && wen != 4'h0) begin
        if (kind == 0) m_ram[idx] = merge(m_ram[idx], wdata, wen);
        if (kind == 1) m_led      = merge({16'h0, m_led}, wdata, wen) & 32'h0000_FFFF;
        if (kind == 3) m_scratch  = merge(m_scratch, wdata, wen);
      end
      drive(en, wen, addr, wdata); step();
      n_tests++; if (sram_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h addr %h", k, sram_rdata, m_rdata, addr); end
      n_tests++; if (led !== m_led)          begin n_fail++; $display("FAIL rand_led[%0d]: got %h want %h", k, led, m_led); end
      n_tests++; if (timer !== m_timer)      begin n_fail++; $display("FAIL rand_timer[%0d]: got %h want %h", k, timer, m_timer); end
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_byte_lanes();
    test_led();
    test_timer_wrap();
    test_unmapped();
    test_reset_midcycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
